// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: low-rate comb chain, zero-stuffing upsampler, high-rate integrators.
// Optional output saturation is enabled by defining CIC_INT_SATURATE_EN (default: two's-complement wrap).
module cic_interpolator #(
  parameter int STAGES        = 3,
  parameter int INTERPOLATION = 16,
  parameter int IN_WIDTH      = 18,
  parameter int OUT_WIDTH     = 18,
  parameter int ACC_WIDTH     = 30,
  parameter int OUT_SHIFT     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 out_strobe,
  output logic                 in_strobe,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int PHASE_W = $clog2(INTERPOLATION);
  localparam int FIELD_W = ACC_WIDTH - OUT_SHIFT;

  logic [PHASE_W-1:0]          phase;
  logic signed [ACC_WIDTH-1:0] comb_in  [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_reg [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_dly [STAGES];
  logic signed [ACC_WIDTH-1:0] integ    [STAGES];
  logic signed [ACC_WIDTH-1:0] stuffed;
  logic [ACC_WIDTH-1:0]        acc_last;
  logic [FIELD_W:0]            rounded;
  logic [OUT_WIDTH-1:0]        out_next;
  logic                        strobe_d;

  // The request is gated by reset so upstream never sees a pull while state is cleared.
  assign in_strobe = out_strobe && (phase == '0) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (out_strobe) begin
      phase <= phase + PHASE_W'(1);
    end
  end

  always_comb begin
    comb_in[0] = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    for (int i = 1; i < STAGES; i++) begin
      comb_in[i] = comb_reg[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        comb_reg[i] <= '0;
        comb_dly[i] <= '0;
      end
    end else if (in_strobe) begin
      for (int i = 0; i < STAGES; i++) begin
        comb_dly[i] <= comb_in[i];
        comb_reg[i] <= comb_in[i] - comb_dly[i];
      end
    end
  end

  // Request cycles inject the comb result registered on the previous request.
  assign stuffed = (phase == '0) ? comb_reg[STAGES-1] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        integ[i] <= '0;
      end
    end else if (out_strobe) begin
      integ[0] <= integ[0] + stuffed;
      for (int i = 1; i < STAGES; i++) begin
        integ[i] <= integ[i] + integ[i-1];
      end
    end
  end

  assign acc_last = integ[STAGES-1];

  generate
    if (OUT_SHIFT > 0) begin : g_round
      assign rounded = {acc_last[ACC_WIDTH-1], acc_last[ACC_WIDTH-1:OUT_SHIFT]}
                     + (FIELD_W+1)'(acc_last[OUT_SHIFT-1]);
    end else begin : g_no_round
      assign rounded = {acc_last[ACC_WIDTH-1], acc_last};
    end
  endgenerate

`ifdef CIC_INT_SATURATE_EN
  // Any disagreement among the bits above the output sign bit means the value is out of range.
  always_comb begin
    out_next = rounded[OUT_WIDTH-1:0];
    if (rounded[FIELD_W:OUT_WIDTH-1] != {(FIELD_W-OUT_WIDTH+2){rounded[FIELD_W]}}) begin
      out_next = rounded[FIELD_W] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign out_next = rounded[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_d  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      strobe_d  <= out_strobe;
      out_valid <= strobe_d;
      if (strobe_d) begin
        out_data <= out_next;
      end
    end
  end

endmodule
